// File: rtl/mem_pkg.sv
// Shared types and constants for the memory / I-O bus controller.
package mem_pkg;

    // Command encoding driven by the CPU control FSM.
    typedef logic [1:0] mem_cmd_t;

    localparam mem_cmd_t MNONE  = 2'b00;
    localparam mem_cmd_t MWRITE = 2'b01;
    localparam mem_cmd_t MREAD  = 2'b11;
    localparam mem_cmd_t MRSVD  = 2'b10;

    // Memory-mapped I/O locations.
    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    // Width of the external RAM word address.
    localparam int RAM_AW = 8;

    // Value returned to the CPU when a RAM read never completes.
    localparam logic [15:0] TIMEOUT_PATTERN = 16'hDEAD;

    // Controller states.
    typedef enum logic {
        IDLE     = 1'b0,
        RAM_WAIT = 1'b1
    } state_t;

    // True for the two commands that perform a bus access.
    function automatic logic is_access(input mem_cmd_t cmd);
        return (cmd == MWRITE) || (cmd == MREAD);
    endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/response and RAM handshake signals of the bus controller.
// The master modport is the controller's view; the slave modport is the view
// of the surrounding CPU datapath and RAM.
interface mem_io_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RAM_AW = 8
);
    import mem_pkg::*;

    // CPU side
    mem_cmd_t            mem_cmd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W-1:0]   read_data;
    logic                mem_busy;

    // RAM side
    logic                ram_req;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic                ram_ack;

    modport master (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output mem_busy,
        output ram_req,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata,
        input  ram_ack
    );

    modport slave (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  mem_busy,
        input  ram_req,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata,
        output ram_ack
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs, one chain per bit.
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            // Capture the raw input, then re-register it to settle metastability.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory / I-O bus controller: decodes CPU accesses to the handshaked RAM,
// the LED register and the synchronised switches; stalls the CPU with
// mem_busy while a RAM transaction is outstanding.
module mem_io_ctrl #(
    parameter int               ADDR_W    = 9,
    parameter int               DATA_W    = 16,
    parameter int               RAM_WORDS = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR = mem_pkg::LED_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR  = mem_pkg::SW_ADDR,
    parameter int               TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                reset,
    mem_io_ctrl_if.master       bus,
    input  logic [7:0]          sw,
    output logic [7:0]          led,
    output logic                bus_err
);
    import mem_pkg::*;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_reg,     state_next;
    logic [CNT_W-1:0]    cnt_reg,       cnt_next;
    logic [DATA_W-1:0]   read_data_reg, read_data_next;
    logic [7:0]          led_reg,       led_next;
    logic                bus_err_reg,   bus_err_next;
    logic                ram_req_reg,   ram_req_next;
    logic                ram_we_reg,    ram_we_next;
    logic [RAM_AW-1:0]   ram_addr_reg,  ram_addr_next;
    logic [DATA_W-1:0]   ram_wdata_reg, ram_wdata_next;
    logic                mem_busy;

    logic [7:0]          sw_sync;
    logic                cmd_access;
    logic                cmd_write;
    logic                ram_hit;
    logic                led_hit;
    logic                sw_hit;

    // Switches arrive asynchronously from the board.
    sync2 #(.WIDTH(8)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_sync)
    );

    // Address / command decode for the access presented this cycle.
    always_comb begin
        cmd_access = is_access(bus.mem_cmd);
        cmd_write  = (bus.mem_cmd == MWRITE);
        ram_hit    = int'(bus.mem_addr) < RAM_WORDS;
        led_hit    = (bus.mem_addr == LED_ADDR);
        sw_hit     = (bus.mem_addr == SW_ADDR);
    end

    // State and output registers; reset withdraws any outstanding RAM request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            read_data_reg <= '0;
            led_reg       <= '0;
            bus_err_reg   <= 1'b0;
            ram_req_reg   <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            read_data_reg <= read_data_next;
            led_reg       <= led_next;
            bus_err_reg   <= bus_err_next;
            ram_req_reg   <= ram_req_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
        end
    end

    // Next-state logic; mem_busy is the only combinational output so the CPU
    // can stall in the decode cycle and resume on the completing edge.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        read_data_next = read_data_reg;
        led_next       = led_reg;
        bus_err_next   = bus_err_reg;
        ram_req_next   = ram_req_reg;
        ram_we_next    = ram_we_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        mem_busy       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.mem_cmd == MRSVD) begin
                    // Reserved encoding performs no access but is flagged.
                    bus_err_next = 1'b1;
                end else if (cmd_access) begin
                    if (ram_hit) begin
                        mem_busy       = 1'b1;
                        ram_req_next   = 1'b1;
                        ram_we_next    = cmd_write;
                        ram_addr_next  = bus.mem_addr[RAM_AW-1:0];
                        ram_wdata_next = bus.write_data;
                        cnt_next       = '0;
                        state_next     = RAM_WAIT;
                    end else if (led_hit) begin
                        if (cmd_write) begin
                            led_next = bus.write_data[7:0];
                        end else begin
                            read_data_next = DATA_W'(led_reg);
                        end
                    end else if (sw_hit) begin
                        // Switches are read-only.
                        if (cmd_write) begin
                            bus_err_next = 1'b1;
                        end else begin
                            read_data_next = DATA_W'(sw_sync);
                        end
                    end else begin
                        // Unmapped: reads return zero, writes are dropped.
                        bus_err_next = 1'b1;
                        if (!cmd_write) begin
                            read_data_next = '0;
                        end
                    end
                end
            end

            RAM_WAIT: begin
                // The latched transaction owns the bus; mem_cmd is ignored here.
                cnt_next = cnt_reg + 1'b1;
                if (bus.ram_ack) begin
                    if (!ram_we_reg) begin
                        read_data_next = bus.ram_rdata;
                    end
                    ram_req_next = 1'b0;
                    state_next   = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    // RAM never answered: abandon the request and flag it.
                    if (!ram_we_reg) begin
                        read_data_next = DATA_W'(TIMEOUT_PATTERN);
                    end
                    ram_req_next = 1'b0;
                    bus_err_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    mem_busy = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.read_data = read_data_reg;
    assign bus.mem_busy  = mem_busy;
    assign bus.ram_req   = ram_req_reg;
    assign bus.ram_we    = ram_we_reg;
    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_wdata = ram_wdata_reg;
    assign led           = led_reg;
    assign bus_err       = bus_err_reg;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed plus randomized bench for mem_io_ctrl with a behavioural model
// of the address map, a bench-side RAM responder and an error flag model.
module tb_mem_io_ctrl;
    import mem_pkg::*;

    localparam int TMO = 15;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] led;
    logic       bus_err;

    mem_io_ctrl_if #(.ADDR_W(9), .DATA_W(16), .RAM_AW(8)) bus ();

    mem_io_ctrl #(
        .ADDR_W    (9),
        .DATA_W    (16),
        .RAM_WORDS (256),
        .LED_ADDR  (9'h100),
        .SW_ADDR   (9'h140),
        .TIMEOUT   (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sw      (sw),
        .led     (led),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [15:0] ram_mem [256];
    logic [15:0] m_rd;
    logic [7:0]  m_led;
    logic [7:0]  m_sw;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access starting at a negedge; returns at the negedge of the
    // IDLE cycle that follows completion, with mem_cmd parked at NONE.
    task automatic access(input mem_cmd_t cmd, input logic [8:0] addr, input logic [15:0] wd,
                          input int ack_at, input bit scramble, input string tag);
        bit          is_wr;
        bit          done;
        int          busy_cnt;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
        logic        exp_err;
        is_wr    = (cmd == MWRITE);
        done     = 1'b0;
        busy_cnt = 0;
        exp_rd   = m_rd;
        exp_led  = m_led;
        exp_err  = m_err;
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wd;
        #1;
        if ((cmd == MREAD || cmd == MWRITE) && addr < 9'd256) begin
            check({tag, ":busy_decode"}, bus.mem_busy, 1);
            busy_cnt = 1;
            for (int k = 1; k <= TMO && !done; k++) begin
                @(negedge clk);
                bus.ram_ack = 1'b0;
                check({tag, ":ram_req"},   bus.ram_req,   1);
                check({tag, ":ram_addr"},  bus.ram_addr,  addr[7:0]);
                check({tag, ":ram_we"},    bus.ram_we,    is_wr);
                check({tag, ":ram_wdata"}, bus.ram_wdata, wd);
                if (scramble) begin
                    bus.mem_cmd    = mem_cmd_t'($urandom_range(0, 3));
                    bus.mem_addr   = 9'($urandom);
                    bus.write_data = 16'($urandom);
                end
                bus.ram_rdata = 16'($urandom);
                if (k == ack_at) begin
                    bus.ram_ack = 1'b1;
                    if (is_wr) begin
                        ram_mem[addr[7:0]] = wd;
                    end else begin
                        bus.ram_rdata = ram_mem[addr[7:0]];
                        exp_rd        = ram_mem[addr[7:0]];
                    end
                    done = 1'b1;
                end else if (k == TMO) begin
                    exp_err = 1'b1;
                    if (!is_wr) exp_rd = 16'hDEAD;
                    done = 1'b1;
                end
                #1;
                if (bus.mem_busy) busy_cnt++;
                check({tag, ":busy_wait"}, bus.mem_busy, !done);
            end
            @(negedge clk);
            bus.ram_ack = 1'b0;
            check({tag, ":busy_cycles"}, busy_cnt, (ack_at >= 1 && ack_at <= TMO) ? ack_at : TMO);
            check({tag, ":req_drop"}, bus.ram_req, 0);
        end else begin
            check({tag, ":busy_io"}, bus.mem_busy, 0);
            if (cmd == MRSVD) begin
                exp_err = 1'b1;
            end else if (cmd != MNONE) begin
                if (addr == 9'h100) begin
                    if (is_wr) exp_led = wd[7:0];
                    else       exp_rd  = {8'h00, m_led};
                end else if (addr == 9'h140) begin
                    if (is_wr) exp_err = 1'b1;
                    else       exp_rd  = {8'h00, m_sw};
                end else begin
                    exp_err = 1'b1;
                    if (!is_wr) exp_rd = 16'h0000;
                end
            end
            @(negedge clk);
        end
        check({tag, ":read_data"}, bus.read_data, exp_rd);
        check({tag, ":led"},       led,           exp_led);
        check({tag, ":bus_err"},   bus_err,       exp_err);
        m_rd  = exp_rd;
        m_led = exp_led;
        m_err = exp_err;
        bus.mem_cmd = MNONE;
        $display("txn %s cmd=%b addr=%h wd=%h ack_at=%0d rd=%h led=%h err=%b",
                 tag, cmd, addr, wd, ack_at, bus.read_data, led, bus_err);
    endtask

    // Idle cycle, optionally with a stray ack that must be ignored.
    task automatic nop(input bit stray_ack);
        bus.mem_cmd = MNONE;
        if (stray_ack) begin
            bus.ram_ack   = 1'b1;
            bus.ram_rdata = 16'($urandom);
        end
        #1;
        check("nop:busy", bus.mem_busy, 0);
        @(negedge clk);
        bus.ram_ack = 1'b0;
        check("nop:rd_hold", bus.read_data, m_rd);
        check("nop:req", bus.ram_req, 0);
    endtask

    task automatic set_sw(input logic [7:0] v);
        sw   = v;
        m_sw = v;
        repeat (3) nop(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        sw             = 8'h00;
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = '0;
        bus.write_data = '0;
        bus.ram_rdata  = '0;
        bus.ram_ack    = 1'b0;
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'($urandom);
        ram_mem[8'h10] = 16'h1234;
        m_rd  = 16'h0000;
        m_led = 8'h00;
        m_sw  = 8'h00;
        m_err = 1'b0;

        // Reset state
        #12;
        check("rst:read_data", bus.read_data, 0);
        check("rst:led",       led,           0);
        check("rst:bus_err",   bus_err,       0);
        check("rst:ram_req",   bus.ram_req,   0);
        check("rst:ram_we",    bus.ram_we,    0);
        check("rst:ram_addr",  bus.ram_addr,  0);
        check("rst:ram_wdata", bus.ram_wdata, 0);
        check("rst:mem_busy",  bus.mem_busy,  0);
        @(negedge clk);
        reset = 1'b1;
        nop(1'b1);

        // LED write and readback
        access(MWRITE, 9'h100, 16'h00A5, 0, 1'b0, "led_wr");
        check("led_wr:const", led, 8'hA5);
        access(MREAD, 9'h100, 16'h0000, 0, 1'b0, "led_rd");
        check("led_rd:const", bus.read_data, 16'h00A5);

        // Switch read, then illegal switch write
        set_sw(8'h3C);
        access(MREAD, 9'h140, 16'h0000, 0, 1'b0, "sw_rd");
        check("sw_rd:const", bus.read_data, 16'h003C);
        access(MWRITE, 9'h140, 16'h0055, 0, 1'b0, "sw_wr");
        check("sw_wr:err_const", bus_err, 1);

        // Switch change seen only after two edges
        sw = 8'hC3;
        nop(1'b0);
        access(MREAD, 9'h140, 16'h0000, 0, 1'b0, "sw_late_old");
        m_sw = 8'hC3;
        access(MREAD, 9'h140, 16'h0000, 0, 1'b0, "sw_late_new");

        // RAM read with ack three cycles after the request
        access(MREAD, 9'h010, 16'h0000, 4, 1'b0, "ram_rd_slow");
        check("ram_rd_slow:const", bus.read_data, 16'h1234);

        // RAM write with immediate ack, then back-to-back read of the same word
        access(MWRITE, 9'h020, 16'hBEEF, 1, 1'b0, "ram_wr_fast");
        access(MREAD, 9'h020, 16'h0000, 2, 1'b1, "ram_b2b_rd");
        check("ram_b2b_rd:const", bus.read_data, 16'hBEEF);

        // RAM timeout, then unmapped read
        access(MREAD, 9'h005, 16'h0000, 0, 1'b0, "ram_tmo");
        check("ram_tmo:const", bus.read_data, 16'hDEAD);
        access(MREAD, 9'h1F0, 16'h0000, 0, 1'b0, "unmapped_rd");

        // Reset in the middle of a RAM wait
        bus.mem_cmd  = MREAD;
        bus.mem_addr = 9'h010;
        @(negedge clk);
        check("mid_rst:req_before", bus.ram_req, 1);
        #2;
        reset       = 1'b0;
        bus.mem_cmd = MNONE;
        #1;
        check("mid_rst:ram_req",   bus.ram_req,   0);
        check("mid_rst:mem_busy",  bus.mem_busy,  0);
        check("mid_rst:led",       led,           0);
        check("mid_rst:read_data", bus.read_data, 0);
        check("mid_rst:bus_err",   bus_err,       0);
        @(negedge clk);
        reset = 1'b1;
        m_rd  = 16'h0000;
        m_led = 8'h00;
        m_err = 1'b0;
        nop(1'b1);

        // Reserved command flags an error without stalling
        access(MRSVD, 9'h010, 16'h0000, 0, 1'b0, "reserved");

        // Randomized traffic against the reference model
        set_sw(8'($urandom));
        for (int n = 0; n < 60; n++) begin
            int          r;
            mem_cmd_t    c;
            logic [8:0]  a;
            logic [15:0] d;
            int          ack;
            r = $urandom_range(0, 9);
            c = ($urandom_range(0, 1) == 1) ? MWRITE : MREAD;
            d = 16'($urandom);
            if (r <= 5) begin
                a   = 9'($urandom_range(0, 31));
                ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
                access(c, a, d, ack, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_ram", n));
            end else if (r == 6) begin
                access(c, 9'h100, d, 0, 1'b0, $sformatf("rnd%0d_led", n));
            end else if (r == 7) begin
                access(c, 9'h140, d, 0, 1'b0, $sformatf("rnd%0d_sw", n));
            end else if (r == 8) begin
                a = 9'h100 + 9'($urandom_range(1, 255));
                if (a == 9'h140) a = 9'h141;
                access(c, a, d, 0, 1'b0, $sformatf("rnd%0d_unmapped", n));
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    access(MRSVD, 9'($urandom), d, 0, 1'b0, $sformatf("rnd%0d_rsvd", n));
                end else begin
                    set_sw(8'($urandom));
                end
            end
            if ($urandom_range(0, 3) == 0) nop(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
